// File: rtl/mul16_seq_ctrl.sv
// rtl/mul16_seq_ctrl.sv - sequential signed 16x16 multiplier, one 4x4 nibble partial product per cycle
// Accepts an operand pair in IDLE, accumulates 16 nibble products in RUN, presents p in DONE.
module mul16_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] p,
   output logic        busy,
   output logic [3:0]  pp_idx
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nx;
   logic [15:0] a_q, b_q;
   logic [31:0] acc;
   logic [3:0]  k;

   logic [1:0]        i, j;
   logic [3:0]        na, nb;
   logic signed [4:0] na_s, nb_s;
   logic signed [9:0] pp;
   logic [31:0]       pp_ext;
   logic [2:0]        ij;
   logic [31:0]       pp_shift;

   assign i = k[3:2];
   assign j = k[1:0];
   assign na = a_q[{i, 2'b00} +: 4];
   assign nb = b_q[{j, 2'b00} +: 4];

   // Only the top nibble carries the operand sign; lower nibbles are plain magnitudes.
   assign na_s = {(i == 2'd3) ? na[3] : 1'b0, na};
   assign nb_s = {(j == 2'd3) ? nb[3] : 1'b0, nb};
   assign pp = na_s * nb_s;
   assign pp_ext = {{22{pp[9]}}, pp};
   assign ij = {1'b0, i} + {1'b0, j};
   assign pp_shift = pp_ext << {ij, 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= 32'd0;
         k     <= 4'd0;
         a_q   <= 16'd0;
         b_q   <= 16'd0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q <= a;
                  b_q <= b;
                  acc <= 32'd0;
                  k   <= 4'd0;
               end
            end
            RUN: begin
               acc <= acc + pp_shift;
               k   <= k + 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            if (k == 4'd15) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign p      = acc;
   assign busy   = (state != IDLE);
   assign pp_idx = (state == RUN) ? k : 4'd0;

endmodule
